sram_1rw1r_arbiter: RTL
=======================

# sram_1rw1r_arbiter

- Shares the 20x256 1RW+1R SRAM macro between three requesters:
  - Requester A (core data, read/write) and requester B (loader/DMA, read/write) share RW port 0 under round-robin arbitration.
  - Requester C (fetch/debug, read-only) owns read port 1.
- Blocks any port-1 read that collides with a same-address port-0 write in the same cycle.
- Captures macro read data into registers and returns it with a one-cycle valid pulse per requester.
- Sits between the core/loader interfaces and the macro; the macro's clk0 and clk1 are tied to this block's clk at the top level.

## Interface
- DATA_WIDTH, 20, data word width
- ADDR_WIDTH, 8, word address width (256 words)

Ports:
- clk  in  1  single clock; all flops use the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_a, req_b  in  1  request; held until granted
- we_a, we_b  in  1  1 = write, 0 = read
- addr_a, addr_b  in  ADDR_WIDTH  word address
- wdata_a, wdata_b  in  DATA_WIDTH  write data
- gnt_a, gnt_b  out  1  combinational grant; the command is accepted when req & gnt are both high at a rising edge
- rvalid_a, rvalid_b  out  1  one-cycle read-data valid
- rdata_a, rdata_b  out  DATA_WIDTH  read data
- req_c  in  1  port-1 read request
- addr_c  in  ADDR_WIDTH  port-1 address
- gnt_c  out  1  combinational grant
- rvalid_c  out  1  one-cycle valid
- rdata_c  out  DATA_WIDTH  read data
- csb0, web0  out  1  macro port 0 chip select / write enable (active low)
- addr0  out  ADDR_WIDTH  macro port 0 address
- din0  out  DATA_WIDTH  macro port 0 write data
- dout0  in  DATA_WIDTH  macro port 0 read data
- csb1  out  1  macro port 1 chip select (active low)
- addr1  out  ADDR_WIDTH  macro port 1 address
- dout1  in  DATA_WIDTH  macro port 1 read data

## Operation
**Port-0 arbitration**
- Round-robin pointer `rr_last` (0 = A, 1 = B).
- If only one of A/B requests, that requester is granted.
- If both request, grant the one that is not `rr_last`.
- `rr_last` is loaded with the granted requester on every accepted port-0 command.

**Port-0 macro drive (combinational from the grant)**
- csb0 = !(gnt_a | gnt_b).
- web0, addr0, din0 come from the granted requester.
- When idle, web0 = 1 and addr0/din0 hold their last values.

**Port-1 grant**
- gnt_c = req_c & !(port-0 write granted & addr0 == addr_c).
- csb1 = !gnt_c; addr1 = addr_c.
- A blocked C keeps req_c high and is granted in a later cycle.

**Read return pipeline**
- Stage-1 flops hold `{pend_valid, pend_src}` per port, where src is A or B for port 0.
- Stage 2 captures dout0/dout1 into rdata_* at the next rising edge and pulses the matching rvalid_*.
- Writes produce no rvalid.
- rdata_* holds its value between pulses.

**Reset** (asynchronous, rst_n low)
- All flops clear: rr_last = 1, so A wins the first contention.
- pend_valid = 0, rvalid_* = 0, rdata_* = 0.
- gnt_a, gnt_b and gnt_c are forced to 0; csb0 = csb1 = 1; web0 = 1.
- Reset mid-read discards the in-flight read; no rvalid appears after reset releases.

## Timing
- Accept edge E: the macro samples its inputs at the same edge E.
- Read accepted in cycle N gives rvalid and rdata valid in cycle N+2, fixed latency 2, on both ports.
- Throughput is one port-0 command and one port-1 read per cycle. Back-to-back reads return in order, one per cycle.
- A write in cycle N is visible to a read accepted in cycle N+1 or later, on either port.
- A same-address write and port-1 read in cycle N: C is granted in cycle N+1 and returns the new data in cycle N+3.
- A port-0 read and a port-1 read to the same address in the same cycle are both granted.
- Different-address write plus port-1 read in the same cycle: both are granted.

## Test plan
- **Reset values:** reset asserted with all req high → csb0 = csb1 = 1, all gnt = 0, all rvalid = 0. After release, first contention grants A.
- **Write then read:** A writes 0xABCDE to address 0x10 in cycle 0; B reads 0x10 in cycle 1 → rvalid_b in cycle 3 with rdata_b = 0xABCDE, and rvalid_a stays 0.
- **Contention:** A and B request continuously for 6 cycles → grants alternate A, B, A, B, A, B. Reads to addresses 0..5 (preloaded k+1) return 1..6 in order with correct rvalid_a/rvalid_b.
- **Collision:** A writes 0x12345 to address 0x20 while C reads 0x20 in cycle 0 → gnt_c = 0 in cycle 0, gnt_c = 1 in cycle 1, rdata_c = 0x12345 in cycle 3. A different address in cycle 0 → gnt_c = 1 immediately.
- **Reset mid-read:** A's read is accepted in cycle 0 and rst_n pulses low in cycle 1 → no rvalid_a appears, and rdata_a = 0.
- **Port-1 streaming:** C reads addresses 0..255 back-to-back after a full B preload of 0xFFFFF - k → 256 rvalid_c pulses, each 2 cycles after its grant, with matching data. Wrap from 0xFF to 0x00 behaves correctly.

Source files
------------

// File: rtl/sram_1rw1r_arbiter.sv
// Arbitration and read-return front end for a 1RW+1R SRAM macro.
// A and B share RW port 0 round-robin; C owns read port 1.
module sram_1rw1r_arbiter #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [DATA_WIDTH-1:0] rdata_a,

    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata_b,

    input  logic                  req_c,
    input  logic [ADDR_WIDTH-1:0] addr_c,
    output logic                  gnt_c,
    output logic                  rvalid_c,
    output logic [DATA_WIDTH-1:0] rdata_c,

    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,

    output logic                  csb1,
    output logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] dout1
);

    logic                  rr_last;
    logic [ADDR_WIDTH-1:0] addr0_hold;
    logic [DATA_WIDTH-1:0] din0_hold;
    logic                  acc0;
    logic                  wr0;
    logic                  pend0_vld_p1;
    logic                  pend0_src_p1;
    logic                  pend1_vld_p1;

    // Grants and macro drive are combinational so the macro samples at the accept edge
    always_comb begin
        gnt_a = rst_n & req_a & (~req_b | rr_last);
        gnt_b = rst_n & req_b & (~req_a | ~rr_last);
        acc0  = gnt_a | gnt_b;
        csb0  = ~acc0;
        if (gnt_a) begin
            web0  = ~we_a;
            addr0 = addr_a;
            din0  = wdata_a;
        end else if (gnt_b) begin
            web0  = ~we_b;
            addr0 = addr_b;
            din0  = wdata_b;
        end else begin
            web0  = 1'b1;
            addr0 = addr0_hold;
            din0  = din0_hold;
        end
        wr0   = acc0 & ~web0;
        // A same-address port-1 read would see stale data, so it waits a cycle
        gnt_c = rst_n & req_c & ~(wr0 & (addr0 == addr_c));
        csb1  = ~gnt_c;
        addr1 = addr_c;
    end

    // Stage 1: remember which reads are in flight; stage 2: raise rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last      <= 1'b1;
            pend0_vld_p1 <= 1'b0;
            pend0_src_p1 <= 1'b0;
            pend1_vld_p1 <= 1'b0;
            rvalid_a     <= 1'b0;
            rvalid_b     <= 1'b0;
            rvalid_c     <= 1'b0;
        end else begin
            if (acc0)
                rr_last <= gnt_b;
            pend0_vld_p1 <= acc0 & web0;
            pend0_src_p1 <= gnt_b;
            pend1_vld_p1 <= gnt_c;
            rvalid_a     <= pend0_vld_p1 & ~pend0_src_p1;
            rvalid_b     <= pend0_vld_p1 &  pend0_src_p1;
            rvalid_c     <= pend1_vld_p1;
        end
    end

    // Stage 2: capture macro read data for the owning requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr0_hold <= '0;
            din0_hold  <= '0;
            rdata_a    <= '0;
            rdata_b    <= '0;
            rdata_c    <= '0;
        end else begin
            if (acc0) begin
                addr0_hold <= addr0;
                din0_hold  <= din0;
            end
            if (pend0_vld_p1 & ~pend0_src_p1)
                rdata_a <= dout0;
            if (pend0_vld_p1 & pend0_src_p1)
                rdata_b <= dout0;
            if (pend1_vld_p1)
                rdata_c <= dout1;
        end
    end

endmodule
